// File: rtl/gba_bus_pkg.sv
// Shared types, widths and address helper for the GBA cartridge ROM bus slave.
package gba_bus_pkg;

    localparam int GBA_ADDR_W = 24;
    localparam int GBA_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_ADDR,
        ST_READ,
        ST_WRITE
    } state_e;

    // Sequential ROM access only walks the low halfword; the bank byte never carries.
    function automatic logic [GBA_ADDR_W-1:0] inc_lo16(input logic [GBA_ADDR_W-1:0] addr);
        return {addr[GBA_ADDR_W-1:16], addr[15:0] + 16'd1};
    endfunction

endpackage

// File: rtl/gba_bus_sync.sv
// Multi-stage flip-flop synchronizer for asynchronous GBA pins.
module gba_sync #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gba_rom_bus.sv
// GBA cartridge ROM bus slave: synchronizes pins, latches the address, issues reads and captures writes.
module gba_rom_bus
    import gba_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = GBA_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gba_ncs,
    input  logic                  gba_nrd,
    input  logic                  gba_nwr,
    input  logic [GBA_DATA_W-1:0] gba_ad_in,
    input  logic [7:0]            gba_a_in,
    output logic [GBA_DATA_W-1:0] gba_ad_out,
    output logic                  gba_ad_oe,
    output logic                  rd_req,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic                  rd_rsp_valid,
    input  logic [GBA_DATA_W-1:0] rd_rsp_data,
    output logic                  wr_valid,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [GBA_DATA_W-1:0] wr_data,
    output logic                  underrun,
    output logic                  bus_err,
    output logic                  active
);

    logic                  ncs_s, nrd_s, nwr_s;
    logic [7:0]            a_s;
    logic [GBA_DATA_W-1:0] ad_s;

    // Strobes reset to "asserted" so a transaction in flight at reset release is never mistaken for a fresh edge.
    gba_sync #(.WIDTH(3), .STAGES(SYNC_STAGES), .RST_VAL(3'b000)) u_sync_strobe (
        .clk (clk),
        .rst (rst),
        .d   ({gba_ncs, gba_nrd, gba_nwr}),
        .q   ({ncs_s, nrd_s, nwr_s})
    );

    gba_sync #(.WIDTH(24), .STAGES(SYNC_STAGES), .RST_VAL(24'h0)) u_sync_bus (
        .clk (clk),
        .rst (rst),
        .d   ({gba_a_in, gba_ad_in}),
        .q   ({a_s, ad_s})
    );

    logic                  ncs_p_q, nrd_p_q, nwr_p_q;
    logic [GBA_DATA_W-1:0] ad_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ncs_p_q   <= 1'b0;
            nrd_p_q   <= 1'b0;
            nwr_p_q   <= 1'b0;
            ad_prev_q <= '0;
        end else begin
            ncs_p_q   <= ncs_s;
            nrd_p_q   <= nrd_s;
            nwr_p_q   <= nwr_s;
            ad_prev_q <= ad_s;
        end
    end

    logic ncs_fall, ncs_rise, nrd_fall, nrd_rise, nwr_fall, nwr_rise;
    assign ncs_fall = ncs_p_q & ~ncs_s;
    assign ncs_rise = ~ncs_p_q & ncs_s;
    assign nrd_fall = nrd_p_q & ~nrd_s;
    assign nrd_rise = ~nrd_p_q & nrd_s;
    assign nwr_fall = nwr_p_q & ~nwr_s;
    assign nwr_rise = ~nwr_p_q & nwr_s;

    state_e                state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  got_rsp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WAIT_IDLE;
            addr_q     <= '0;
            got_rsp_q  <= 1'b0;
            gba_ad_out <= '0;
            gba_ad_oe  <= 1'b0;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            underrun   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            rd_req   <= 1'b0;
            wr_valid <= 1'b0;
            underrun <= 1'b0;
            bus_err  <= 1'b0;
            // Chip-select release aborts whatever is pending, ahead of any strobe rise.
            if (state_q != ST_WAIT_IDLE && ncs_rise) begin
                state_q   <= ST_IDLE;
                gba_ad_oe <= 1'b0;
            end else begin
                case (state_q)
                    ST_WAIT_IDLE: if (ncs_s) state_q <= ST_IDLE;
                    ST_IDLE: begin
                        if (ncs_fall) begin
                            addr_q  <= {a_s, ad_s};
                            state_q <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if ((nrd_fall && (nwr_fall || !nwr_s)) || (nwr_fall && !nrd_s)) begin
                            bus_err <= 1'b1;
                        end else if (nrd_fall) begin
                            rd_req    <= 1'b1;
                            rd_addr   <= addr_q;
                            got_rsp_q <= 1'b0;
                            state_q   <= ST_READ;
                        end else if (nwr_fall) begin
                            state_q <= ST_WRITE;
                        end
                    end
                    ST_READ: begin
                        if (nrd_rise) begin
                            addr_q    <= inc_lo16(addr_q);
                            gba_ad_oe <= 1'b0;
                            underrun  <= ~got_rsp_q;
                            state_q   <= ST_ADDR;
                        end else begin
                            gba_ad_oe <= 1'b1;
                            if (rd_rsp_valid && !got_rsp_q) begin
                                got_rsp_q  <= 1'b1;
                                gba_ad_out <= rd_rsp_data;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (nwr_rise) begin
                            wr_valid <= 1'b1;
                            wr_addr  <= addr_q;
                            wr_data  <= ad_prev_q;
                            addr_q   <= inc_lo16(addr_q);
                            state_q  <= ST_ADDR;
                        end
                    end
                    default: state_q <= ST_WAIT_IDLE;
                endcase
            end
        end
    end

    assign active = (state_q == ST_ADDR) || (state_q == ST_READ) || (state_q == ST_WRITE);

endmodule

// File: tb/tb_gba_rom_bus.sv
// Directed self-checking bench for gba_rom_bus with hand-computed expectations.
module tb_gba_rom_bus;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gba_ncs = 1'b1, gba_nrd = 1'b1, gba_nwr = 1'b1;
    logic [15:0] gba_ad_in = 16'h0;
    logic [7:0]  gba_a_in = 8'h0;
    logic [15:0] gba_ad_out;
    logic        gba_ad_oe;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        rd_rsp_valid = 1'b0;
    logic [15:0] rd_rsp_data = 16'h0;
    logic        wr_valid;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic        underrun, bus_err, active;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] rd_q[$];
    int          wr_cnt = 0;
    int          und_cnt = 0;
    int          err_cnt = 0;
    logic [23:0] last_wr_addr;
    logic [15:0] last_wr_data;

    always #5 clk = ~clk;

    gba_rom_bus #(.SYNC_STAGES(2), .ADDR_W(24)) dut (
        .clk          (clk),
        .rst          (rst),
        .gba_ncs      (gba_ncs),
        .gba_nrd      (gba_nrd),
        .gba_nwr      (gba_nwr),
        .gba_ad_in    (gba_ad_in),
        .gba_a_in     (gba_a_in),
        .gba_ad_out   (gba_ad_out),
        .gba_ad_oe    (gba_ad_oe),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .underrun     (underrun),
        .bus_err      (bus_err),
        .active       (active)
    );

    // Pulse monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (rd_req) rd_q.push_back(rd_addr);
        if (wr_valid) begin
            wr_cnt++;
            last_wr_addr = wr_addr;
            last_wr_data = wr_data;
        end
        if (underrun) und_cnt++;
        if (bus_err) err_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rd(output int waited);
        waited = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (rd_req) begin
                waited = i;
                break;
            end
        end
        vectors++;
        if (waited == 0) begin
            miscompares++;
            $display("FAIL rd_req_timeout: no rd_req within 10 cycles, required one");
        end
    endtask

    task automatic cs_low(input logic [7:0] a, input logic [15:0] ad);
        gba_a_in  = a;
        gba_ad_in = ad;
        gba_ncs   = 1'b0;
        cycles(5);
    endtask

    task automatic cs_high();
        gba_ncs = 1'b1;
        cycles(5);
    endtask

    task automatic rd_pulse(input logic respond, input logic [15:0] data);
        int w;
        gba_nrd = 1'b0;
        wait_rd(w);
        if (respond) begin
            cycles(2);
            rd_rsp_valid = 1'b1;
            rd_rsp_data  = data;
            cycles(1);
            rd_rsp_valid = 1'b0;
        end else begin
            cycles(3);
        end
        cycles(2);
        gba_nrd = 1'b1;
        cycles(5);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycles(3);
        vectors++;
        if (gba_ad_oe !== 1'b0 || gba_ad_out !== 16'h0 || active !== 1'b0 ||
            rd_req !== 1'b0 || wr_valid !== 1'b0 || underrun !== 1'b0 || bus_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: oe=%b out=%h active=%b rd_req=%b wr_valid=%b und=%b err=%b, required all 0",
                     gba_ad_oe, gba_ad_out, active, rd_req, wr_valid, underrun, bus_err);
        end
        rst = 1'b0;
        cycles(5);
    endtask

    task automatic test_read();
        int w;
        cs_low(8'h12, 16'h3456);
        vectors++;
        if (active !== 1'b1) begin
            miscompares++;
            $display("FAIL read_active: active=%b, required 1", active);
        end
        gba_nrd = 1'b0;
        wait_rd(w);
        vectors++;
        if (w != 3) begin
            miscompares++;
            $display("FAIL read_latency: rd_req after %0d cycles, required 3", w);
        end
        vectors++;
        if (rd_addr !== 24'h123456) begin
            miscompares++;
            $display("FAIL read_addr: rd_addr=%h, required 123456", rd_addr);
        end
        cycles(2);
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = 16'hBEEF;
        cycles(1);
        rd_rsp_valid = 1'b0;
        cycles(2);
        vectors++;
        if (gba_ad_out !== 16'hBEEF || gba_ad_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL read_drive: out=%h oe=%b, required BEEF oe=1", gba_ad_out, gba_ad_oe);
        end
        gba_nrd = 1'b1;
        cycles(5);
        vectors++;
        if (gba_ad_oe !== 1'b0 || rd_q.size() != 1 || und_cnt != 0) begin
            miscompares++;
            $display("FAIL read_release: oe=%b rd_reqs=%0d underruns=%0d, required oe=0 1 0",
                     gba_ad_oe, rd_q.size(), und_cnt);
        end
    endtask

    task automatic test_burst();
        logic [23:0] exp_addr [4];
        exp_addr[0] = 24'h01FFFE;
        exp_addr[1] = 24'h01FFFF;
        exp_addr[2] = 24'h010000;
        exp_addr[3] = 24'h010001;
        cs_high();
        vectors++;
        if (active !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_idle: active=%b, required 0", active);
        end
        rd_q.delete();
        cs_low(8'h01, 16'hFFFE);
        for (int i = 0; i < 4; i++) rd_pulse(1'b1, 16'hA000 + 16'(i));
        vectors++;
        if (rd_q.size() != 4) begin
            miscompares++;
            $display("FAIL burst_count: %0d rd_reqs, required 4", rd_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (rd_q[i] !== exp_addr[i]) begin
                    miscompares++;
                    $display("FAIL burst_addr%0d: rd_addr=%h, required %h", i, rd_q[i], exp_addr[i]);
                end
            end
        end
    endtask

    task automatic test_underrun();
        int und0;
        und0 = und_cnt;
        rd_pulse(1'b0, 16'h0);
        vectors++;
        if (und_cnt != und0 + 1 || gba_ad_out !== 16'hA003) begin
            miscompares++;
            $display("FAIL underrun_pulse: underruns=%0d out=%h, required %0d A003",
                     und_cnt - und0, gba_ad_out, 1);
        end
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = 16'h1111;
        cycles(1);
        rd_rsp_valid = 1'b0;
        cycles(3);
        vectors++;
        if (gba_ad_out !== 16'hA003 || und_cnt != und0 + 1) begin
            miscompares++;
            $display("FAIL late_rsp_ignored: out=%h, required A003", gba_ad_out);
        end
    endtask

    task automatic test_write();
        int wr0;
        wr0 = wr_cnt;
        cs_high();
        cs_low(8'h00, 16'h0100);
        gba_ad_in = 16'hCAFE;
        cycles(1);
        gba_nwr = 1'b0;
        cycles(4);
        vectors++;
        if (gba_ad_oe !== 1'b0 || active !== 1'b1) begin
            miscompares++;
            $display("FAIL write_phase: oe=%b active=%b, required 0 1", gba_ad_oe, active);
        end
        gba_nwr = 1'b1;
        cycles(6);
        vectors++;
        if (wr_cnt != wr0 + 1 || last_wr_addr !== 24'h000100 || last_wr_data !== 16'hCAFE) begin
            miscompares++;
            $display("FAIL write_capture: count=%0d addr=%h data=%h, required 1 000100 CAFE",
                     wr_cnt - wr0, last_wr_addr, last_wr_data);
        end
        rd_pulse(1'b1, 16'h5555);
        vectors++;
        if (rd_q[$] !== 24'h000101) begin
            miscompares++;
            $display("FAIL write_then_read: rd_addr=%h, required 000101", rd_q[$]);
        end
    endtask

    task automatic test_bus_err();
        int n_rd, wr0, err0;
        n_rd = rd_q.size();
        wr0  = wr_cnt;
        err0 = err_cnt;
        gba_nrd = 1'b0;
        gba_nwr = 1'b0;
        cycles(6);
        vectors++;
        if (err_cnt != err0 + 1 || rd_q.size() != n_rd || wr_cnt != wr0 || active !== 1'b1) begin
            miscompares++;
            $display("FAIL bus_err_pulse: errs=%0d rd_reqs=%0d wr=%0d active=%b, required 1 0 0 1",
                     err_cnt - err0, rd_q.size() - n_rd, wr_cnt - wr0, active);
        end
        gba_nrd = 1'b1;
        gba_nwr = 1'b1;
        cycles(5);
        rd_pulse(1'b1, 16'h7777);
        vectors++;
        if (rd_q.size() != n_rd + 1 || rd_q[$] !== 24'h000102 || wr_cnt != wr0) begin
            miscompares++;
            $display("FAIL bus_err_stays_addr: rd_addr=%h wr=%0d, required 000102 0",
                     rd_q[$], wr_cnt - wr0);
        end
    endtask

    task automatic test_cs_rise_wins();
        int w, und0;
        und0 = und_cnt;
        gba_nrd = 1'b0;
        wait_rd(w);
        cycles(3);
        gba_nrd = 1'b1;
        gba_ncs = 1'b1;
        cycles(6);
        vectors++;
        if (und_cnt != und0 || gba_ad_oe !== 1'b0 || active !== 1'b0) begin
            miscompares++;
            $display("FAIL cs_rise_wins: underruns=%0d oe=%b active=%b, required 0 0 0",
                     und_cnt - und0, gba_ad_oe, active);
        end
    endtask

    task automatic test_reset_in_read();
        int w, n_rd;
        cs_low(8'h00, 16'h0200);
        gba_nrd = 1'b0;
        wait_rd(w);
        cycles(3);
        vectors++;
        if (gba_ad_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_read_oe_pre: oe=%b, required 1", gba_ad_oe);
        end
        rst = 1'b1;
        cycles(1);
        vectors++;
        if (gba_ad_oe !== 1'b0 || active !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_read_oe_post: oe=%b active=%b, required 0 0", gba_ad_oe, active);
        end
        rst = 1'b0;
        n_rd = rd_q.size();
        cycles(10);
        gba_nrd = 1'b1;
        cycles(5);
        gba_nrd = 1'b0;
        cycles(5);
        gba_nrd = 1'b1;
        cycles(5);
        vectors++;
        if (rd_q.size() != n_rd || active !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_ignore_inflight: rd_reqs=%0d active=%b, required 0 0",
                     rd_q.size() - n_rd, active);
        end
        cs_high();
        cs_low(8'h00, 16'h0300);
        rd_pulse(1'b1, 16'h9999);
        vectors++;
        if (rd_q.size() != n_rd + 1 || rd_q[$] !== 24'h000300) begin
            miscompares++;
            $display("FAIL rst_recover: rd_reqs=%0d rd_addr=%h, required 1 000300",
                     rd_q.size() - n_rd, rd_q[$]);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_burst();
        test_underrun();
        test_write();
        test_bus_err();
        test_cs_rise_wins();
        test_reset_in_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
